// File: rtl/wb_mem_bist.sv
// rtl/wb_mem_bist.sv - Wishbone classic memory BIST master: write pass, then read-compare pass
// Optional LFSR data pattern is built when WB_BIST_LFSR_EN is defined.

module wb_mem_bist #(
   parameter int APP_AW = 26,
   parameter int APP_DW = 32,
   parameter int APP_BW = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic [APP_AW-1:0] cfg_base_addr,
   input  logic [15:0]       cfg_num_words,
   input  logic [31:0]       cfg_seed,
`ifdef WB_BIST_LFSR_EN
   input  logic              pattern_sel,
`endif
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [APP_AW-1:0] wb_adr_o,
   output logic [APP_BW-1:0] wb_sel_o,
   output logic [APP_DW-1:0] wb_dat_o,
   input  logic [APP_DW-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_count,
   output logic [APP_AW-1:0] first_err_addr
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR     = 3'd1,
      S_WR_GAP = 3'd2,
      S_RD     = 3'd3,
      S_RD_GAP = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Watchdog fires on the cycle its count would reach 1023.
   localparam logic [9:0] WDOG_LAST = 10'd1022;

   state_t            state_q, state_d;
   logic [15:0]       idx_q, idx_d;
   logic [15:0]       num_q, num_d;
   logic [APP_AW-1:0] base_q, base_d;
   logic [31:0]       seed_q, seed_d;
   logic [9:0]        wdog_q, wdog_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [APP_AW-1:0] first_err_q, first_err_d;

   logic              start_ok;
   logic              acked;
   logic              wd_expire;
   logic              last_word;
   logic              mismatch;
   logic [APP_AW-1:0] cur_adr;
   logic [APP_DW-1:0] pattern;

`ifdef WB_BIST_LFSR_EN
   logic              psel_q, psel_d;
   logic [31:0]       lfsr_q, lfsr_d;

   // Right-shifting Galois LFSR, x^32 + x^22 + x^2 + x + 1
   function automatic logic [31:0] lfsr_next(input logic [31:0] l);
      lfsr_next = {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
   endfunction

   // An all-zero LFSR would lock up, so a zero seed becomes 1
   function automatic logic [31:0] lfsr_load(input logic [31:0] s);
      lfsr_load = (s == 32'h0) ? 32'h0000_0001 : s;
   endfunction
`endif

   // Shared decodes: accepted start, acknowledged strobe, watchdog expiry, address and pattern
   always_comb begin
      start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      acked     = wb_stb_o && wb_ack_i;
      wd_expire = wb_stb_o && !wb_ack_i && (wdog_q == WDOG_LAST);
      last_word = (idx_q == num_q);
      cur_adr   = base_q + APP_AW'({idx_q, 2'b00});
`ifdef WB_BIST_LFSR_EN
      pattern   = psel_q ? lfsr_q : (seed_q ^ {16'h0000, idx_q});
`else
      pattern   = seed_q ^ {16'h0000, idx_q};
`endif
      mismatch  = (state_q == S_RD) && acked && (wb_dat_i != pattern);
   end

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = (cfg_num_words == 16'h0) ? S_DONE : S_WR;
            end
         end
         S_WR: begin
            if (acked) begin
               state_d = S_WR_GAP;
            end else if (wd_expire) begin
               state_d = S_DONE;
            end
         end
         S_WR_GAP: begin
            state_d = last_word ? S_RD : S_WR;
         end
         S_RD: begin
            if (acked) begin
               state_d = S_RD_GAP;
            end else if (wd_expire) begin
               state_d = S_DONE;
            end
         end
         S_RD_GAP: begin
            state_d = last_word ? S_DONE : S_RD;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus and status outputs; the bus is quiet outside the WR and RD states
   always_comb begin
      wb_cyc_o = 1'b0;
      wb_stb_o = 1'b0;
      wb_we_o  = 1'b0;
      wb_adr_o = '0;
      wb_sel_o = '0;
      wb_dat_o = '0;
      case (state_q)
         S_WR: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            wb_adr_o = cur_adr;
            wb_sel_o = '1;
            wb_dat_o = pattern;
         end
         S_RD: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_adr_o = cur_adr;
            wb_sel_o = '1;
         end
         default: begin
         end
      endcase
      busy           = busy_q;
      done           = done_q;
      pass           = pass_q;
      timeout        = timeout_q;
      err_count      = err_cnt_q;
      first_err_addr = first_err_q;
   end

   // Datapath next values: configuration latch, word index, watchdog, compare results
   always_comb begin
      idx_d       = idx_q;
      num_d       = num_q;
      base_d      = base_q;
      seed_d      = seed_q;
      wdog_d      = wdog_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
`ifdef WB_BIST_LFSR_EN
      psel_d      = psel_q;
      lfsr_d      = lfsr_q;
`endif

      if (start_ok) begin
         num_d       = cfg_num_words;
         base_d      = {cfg_base_addr[APP_AW-1:2], 2'b00};
         seed_d      = cfg_seed;
         idx_d       = 16'h0;
         wdog_d      = 10'h0;
         err_cnt_d   = 16'h0;
         first_err_d = '0;
         timeout_d   = 1'b0;
         // An empty test completes immediately and trivially passes
         busy_d      = (cfg_num_words != 16'h0);
         done_d      = (cfg_num_words == 16'h0);
         pass_d      = (cfg_num_words == 16'h0);
`ifdef WB_BIST_LFSR_EN
         psel_d      = pattern_sel;
         lfsr_d      = lfsr_load(cfg_seed);
`endif
      end

      if ((state_q == S_WR) || (state_q == S_RD)) begin
         if (acked) begin
            wdog_d = 10'h0;
            idx_d  = idx_q + 16'h1;
`ifdef WB_BIST_LFSR_EN
            lfsr_d = lfsr_next(lfsr_q);
`endif
         end else begin
            wdog_d = wdog_q + 10'h1;
         end
         if (wd_expire) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
         end
      end

      if (mismatch) begin
         if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'h1;
         end
         if (err_cnt_q == 16'h0) begin
            first_err_d = cur_adr;
         end
      end

      // Read pass restarts at word 0 with the pattern generator rewound
      if ((state_q == S_WR_GAP) && last_word) begin
         idx_d = 16'h0;
`ifdef WB_BIST_LFSR_EN
         lfsr_d = lfsr_load(seed_q);
`endif
      end

      if ((state_q == S_RD_GAP) && last_word) begin
         busy_d = 1'b0;
         done_d = 1'b1;
         pass_d = (err_cnt_q == 16'h0);
      end
   end

   // Datapath registers
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         idx_q       <= 16'h0;
         num_q       <= 16'h0;
         base_q      <= '0;
         seed_q      <= 32'h0;
         wdog_q      <= 10'h0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_cnt_q   <= 16'h0;
         first_err_q <= '0;
`ifdef WB_BIST_LFSR_EN
         psel_q      <= 1'b0;
         lfsr_q      <= 32'h0;
`endif
      end else begin
         idx_q       <= idx_d;
         num_q       <= num_d;
         base_q      <= base_d;
         seed_q      <= seed_d;
         wdog_q      <= wdog_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
`ifdef WB_BIST_LFSR_EN
         psel_q      <= psel_d;
         lfsr_q      <= lfsr_d;
`endif
      end
   end

endmodule
